// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//  Shared definitions for the instruction-side control path and the
//  register/ALU datapath: RV32 opcode/funct constants for the supported
//  subset (ADDI, ADD, BNE), the sequencer state type and the bit positions
//  of the instruction fields.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Major opcodes of the supported instructions
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 / funct7 qualifiers
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    // Instruction-field slice positions
    localparam int OPC_LSB     = 0;
    localparam int RD_LSB      = 7;
    localparam int F3_LSB      = 12;
    localparam int RS1_LSB     = 15;
    localparam int RS2_LSB     = 20;
    localparam int F7_LSB      = 25;
    localparam int REG_FIELD_W = 5;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } ctrl_state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] ir);
        return ir[OPC_LSB +: 7];
    endfunction

    function automatic logic [2:0] funct3_of(input logic [31:0] ir);
        return ir[F3_LSB +: 3];
    endfunction

    function automatic logic [6:0] funct7_of(input logic [31:0] ir);
        return ir[F7_LSB +: 7];
    endfunction

endpackage

// File: rtl/control_path_imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
//  Combinational immediate generator for the I and B instruction formats.
//  Ports:
//   ir     in  DATA_WIDTH  instruction word
//   imm_i  out DATA_WIDTH  sign-extended I-type immediate IR[31:20]
//   imm_b  out DATA_WIDTH  sign-extended B-type branch offset (bit0 = 0)
// ---------------------------------------------------------------------------
module imm_gen #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] imm_b
);

    assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};

    // B format scatters the offset: {imm12, imm11, imm10:5, imm4:1, 0}
    assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

endmodule

// File: rtl/control_path.sv
// ---------------------------------------------------------------------------
// control_path
//  Multi-cycle instruction sequencer (one instruction in flight). Owns the
//  PC, fetches over a req/valid handshake, decodes ADDI/ADD/BNE and drives
//  the datapath controls. BNE is resolved with the datapath EQ flag.
//  Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  fetch request and address (= PC), held until valid
//   imem_rdata/valid    instruction word and its strobe (used in FETCH only)
//   EQ                  datapath RD1 == RD2, sampled in EXEC
//   RegWrite            register-file write pulse (EXEC, rd != 0)
//   ALUsrc              1 = ImmOp is ALU operand 2
//   rs1, rs2, rd        register addresses
//   ImmOp               sign-extended immediate
//   illegal             sticky: bad opcode or misaligned branch target
// ---------------------------------------------------------------------------
module control_path
    import cpu_pkg::*;
#(
    parameter int                    ADDRESS_WIDTH = 5,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [DATA_WIDTH-1:0]    imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     imem_valid,
    input  logic                     EQ,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    ImmOp,
    output logic                     illegal
);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_FETCH  = FETCH;
    localparam logic [2:0] ST_DECODE = DECODE;
    localparam logic [2:0] ST_EXEC   = EXEC;
    localparam logic [2:0] ST_HALT   = HALT;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(3'd4);

    logic [2:0]               state_q,     state_d;
    logic [DATA_WIDTH-1:0]    pc_q,        pc_d;
    logic [DATA_WIDTH-1:0]    ir_q,        ir_d;
    logic                     imem_req_q,  imem_req_d;
    logic [DATA_WIDTH-1:0]    imem_addr_q, imem_addr_d;
    logic                     reg_write_q, reg_write_d;
    logic                     alu_src_q,   alu_src_d;
    logic [ADDRESS_WIDTH-1:0] rs1_q,       rs1_d;
    logic [ADDRESS_WIDTH-1:0] rs2_q,       rs2_d;
    logic [ADDRESS_WIDTH-1:0] rd_q,        rd_d;
    logic [DATA_WIDTH-1:0]    imm_q,       imm_d;
    logic                     illegal_q,   illegal_d;

    logic [DATA_WIDTH-1:0]    imm_i_s;
    logic [DATA_WIDTH-1:0]    imm_b_s;
    logic                     is_addi_s;
    logic                     is_add_s;
    logic                     is_bne_s;
    logic [ADDRESS_WIDTH-1:0] ir_rs1_s;
    logic [ADDRESS_WIDTH-1:0] ir_rs2_s;
    logic [ADDRESS_WIDTH-1:0] ir_rd_s;
    logic [DATA_WIDTH-1:0]    pc_seq_s;
    logic [DATA_WIDTH-1:0]    br_target_s;

    imm_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_imm_gen (
        .ir    (ir_q),
        .imm_i (imm_i_s),
        .imm_b (imm_b_s)
    );

    // IR stays unchanged from capture until the next fetch, so the decode
    // below is valid in both DECODE and EXEC.
    assign is_addi_s = (opcode_of(ir_q) == OPC_OP_IMM) && (funct3_of(ir_q) == F3_ADDI);
    assign is_add_s  = (opcode_of(ir_q) == OPC_OP) && (funct3_of(ir_q) == F3_ADD)
                       && (funct7_of(ir_q) == F7_ADD);
    assign is_bne_s  = (opcode_of(ir_q) == OPC_BRANCH) && (funct3_of(ir_q) == F3_BNE);

    assign ir_rs1_s = ADDRESS_WIDTH'(ir_q[RS1_LSB +: REG_FIELD_W]);
    assign ir_rs2_s = ADDRESS_WIDTH'(ir_q[RS2_LSB +: REG_FIELD_W]);
    assign ir_rd_s  = ADDRESS_WIDTH'(ir_q[RD_LSB  +: REG_FIELD_W]);

    // Both adds wrap modulo 2^DATA_WIDTH.
    assign pc_seq_s    = pc_q + PC_STEP;
    assign br_target_s = pc_q + imm_q;

    // Sequencer next-state, PC/IR and registered control outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        reg_write_d = 1'b0;
        alu_src_d   = alu_src_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        imm_d       = imm_q;
        illegal_d   = illegal_q;

        case (state_q)
            ST_IDLE: begin
                state_d     = ST_FETCH;
                imem_req_d  = 1'b1;
                imem_addr_d = pc_q;
            end

            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = ST_DECODE;
                end else begin
                    imem_req_d = 1'b1;
                end
            end

            ST_DECODE: begin
                if (is_addi_s) begin
                    alu_src_d   = 1'b1;
                    rs1_d       = ir_rs1_s;
                    rs2_d       = '0;
                    rd_d        = ir_rd_s;
                    imm_d       = imm_i_s;
                    reg_write_d = (ir_rd_s != '0);
                    state_d     = ST_EXEC;
                end else if (is_add_s) begin
                    alu_src_d   = 1'b0;
                    rs1_d       = ir_rs1_s;
                    rs2_d       = ir_rs2_s;
                    rd_d        = ir_rd_s;
                    imm_d       = '0;
                    reg_write_d = (ir_rd_s != '0);
                    state_d     = ST_EXEC;
                end else if (is_bne_s) begin
                    alu_src_d = 1'b0;
                    rs1_d     = ir_rs1_s;
                    rs2_d     = ir_rs2_s;
                    rd_d      = '0;
                    imm_d     = imm_b_s;
                    state_d   = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end

            ST_EXEC: begin
                // Taken branch: a target with bit1 set cannot be fetched,
                // so stop with the PC left on the branch.
                if (is_bne_s && !EQ) begin
                    if (br_target_s[1]) begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        pc_d        = br_target_s;
                        imem_req_d  = 1'b1;
                        imem_addr_d = br_target_s;
                        state_d     = ST_FETCH;
                    end
                end else begin
                    pc_d        = pc_seq_s;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_seq_s;
                    state_d     = ST_FETCH;
                end
            end

            ST_HALT: begin
                imem_req_d = 1'b0;
                illegal_d  = 1'b1;
            end

            default: begin
                imem_req_d = 1'b0;
                illegal_d  = 1'b1;
                state_d    = ST_HALT;
            end
        endcase
    end

    // State, PC, IR and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            reg_write_q <= 1'b0;
            alu_src_q   <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            reg_write_q <= reg_write_d;
            alu_src_q   <= alu_src_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign RegWrite  = reg_write_q;
    assign ALUsrc    = alu_src_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign ImmOp     = imm_q;
    assign illegal   = illegal_q;

endmodule
